// File: rtl/wt_mem_req_arbiter.sv
// wt_mem_req_arbiter: N-channel arbiter from L1 miss/write interfaces onto a
// single memory adapter port. Granted requests are tagged {src, tid}; returns
// are routed back by src, invalidations are broadcast to every master.
// Ports:
//   clk_i, rst_ni                 clock, synchronous active-low reset
//   req_valid_i/req_ack_o         per-master request / one-cycle grant
//   req_tid_i, req_data_i         per-master TID and payload (packed by master)
//   mem_req_o/mem_ack_i           held request to adapter / adapter accept
//   mem_tid_o, mem_data_o         {src, tid} and payload of the held request
//   mem_rtrn_*_i                  return beat from adapter (never stalled)
//   rtrn_vld_o, rtrn_tid_o, rtrn_data_o  per-master strobe, shared TID/payload
//   idle_o                        nothing held and nothing outstanding
//   err_o                         sticky protocol error
module wt_mem_req_arbiter #(
    parameter int unsigned NumMasters     = 2,
    parameter int unsigned TidWidth       = 2,
    parameter int unsigned ReqWidth       = 128,
    parameter int unsigned RtrnWidth      = 256,
    parameter int unsigned MaxOutstanding = 8,
    parameter int unsigned FixedPrio      = 0
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic [NumMasters-1:0]                  req_valid_i,
    output logic [NumMasters-1:0]                  req_ack_o,
    input  logic [NumMasters*TidWidth-1:0]         req_tid_i,
    input  logic [NumMasters*ReqWidth-1:0]         req_data_i,
    output logic                                   mem_req_o,
    input  logic                                   mem_ack_i,
    output logic [((NumMasters > 1) ? $clog2(NumMasters) : 1)+TidWidth-1:0] mem_tid_o,
    output logic [ReqWidth-1:0]                    mem_data_o,
    input  logic                                   mem_rtrn_vld_i,
    input  logic                                   mem_rtrn_bcast_i,
    input  logic [((NumMasters > 1) ? $clog2(NumMasters) : 1)+TidWidth-1:0] mem_rtrn_tid_i,
    input  logic [RtrnWidth-1:0]                   mem_rtrn_data_i,
    output logic [NumMasters-1:0]                  rtrn_vld_o,
    output logic [TidWidth-1:0]                    rtrn_tid_o,
    output logic [RtrnWidth-1:0]                   rtrn_data_o,
    output logic                                   idle_o,
    output logic                                   err_o
);

    localparam int unsigned SrcW    = (NumMasters > 1) ? $clog2(NumMasters) : 1;
    localparam int unsigned MemTidW = SrcW + TidWidth;
    localparam int unsigned CntW    = $clog2(MaxOutstanding + 1);

    // held request slot
    logic                slot_vld_q, slot_vld_d;
    logic [SrcW-1:0]     slot_src_q, slot_src_d;
    logic [TidWidth-1:0] slot_tid_q, slot_tid_d;
    logic [ReqWidth-1:0] slot_data_q, slot_data_d;

    logic [SrcW-1:0]     ptr_q, ptr_d;
    logic [CntW-1:0]     cnt_q [NumMasters];
    logic [CntW-1:0]     cnt_d [NumMasters];
    logic                err_q, err_d;
    logic                idle_q, idle_d;

    logic                  slot_free;
    logic [NumMasters-1:0] eligible;
    logic                  gnt_vld;
    logic [SrcW-1:0]       gnt_idx;
    logic [SrcW-1:0]       cand;
    logic [SrcW-1:0]       rtrn_src;
    logic                  src_ok;
    logic [NumMasters-1:0] rtrn_hit;
    logic                  underflow;
    logic                  cnt_all_zero;

    // An acked slot can be refilled in the same cycle (ack-through)
    assign slot_free = !slot_vld_q || mem_ack_i;

    // Eligibility uses the registered count only
    always_comb begin
        eligible = '0;
        for (int unsigned m = 0; m < NumMasters; m++) begin
            eligible[m] = req_valid_i[m] && (cnt_q[m] < CntW'(MaxOutstanding));
        end
    end

    // Winner search: circular from ptr_q, or from 0 in fixed-priority mode
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int unsigned off = 0; off < NumMasters; off++) begin
            if (FixedPrio != 0) begin
                cand = SrcW'(off);
            end else begin
                cand = SrcW'((32'(ptr_q) + off) % NumMasters);
            end
            if (!gnt_vld && eligible[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
        gnt_vld = gnt_vld && slot_free;
    end

    always_comb begin
        req_ack_o = '0;
        if (gnt_vld) begin
            req_ack_o[gnt_idx] = 1'b1;
        end
    end

    // Return routing (combinational, zero latency)
    assign rtrn_src    = mem_rtrn_tid_i[MemTidW-1:TidWidth];
    assign src_ok      = 32'(rtrn_src) < NumMasters;
    assign rtrn_tid_o  = mem_rtrn_tid_i[TidWidth-1:0];
    assign rtrn_data_o = mem_rtrn_data_i;

    always_comb begin
        rtrn_hit  = '0;
        underflow = 1'b0;
        for (int unsigned m = 0; m < NumMasters; m++) begin
            rtrn_hit[m] = mem_rtrn_vld_i && !mem_rtrn_bcast_i && (32'(rtrn_src) == m);
            if (rtrn_hit[m] && (cnt_q[m] == '0)) begin
                underflow = 1'b1;
            end
        end
        rtrn_vld_o = (mem_rtrn_vld_i && mem_rtrn_bcast_i) ? '1 : rtrn_hit;
    end

    // Next-state: slot, pointer, counters, error, idle
    always_comb begin
        slot_vld_d   = slot_vld_q;
        slot_src_d   = slot_src_q;
        slot_tid_d   = slot_tid_q;
        slot_data_d  = slot_data_q;
        ptr_d        = ptr_q;
        cnt_all_zero = 1'b1;

        if (slot_free) begin
            slot_vld_d = gnt_vld;
            if (gnt_vld) begin
                slot_src_d  = gnt_idx;
                slot_tid_d  = req_tid_i[gnt_idx*TidWidth +: TidWidth];
                slot_data_d = req_data_i[gnt_idx*ReqWidth +: ReqWidth];
                ptr_d = (32'(gnt_idx) == NumMasters - 1) ? '0 : gnt_idx + SrcW'(1);
            end
        end

        // grant and return on the same master cancel out
        for (int unsigned m = 0; m < NumMasters; m++) begin
            cnt_d[m] = cnt_q[m];
            if (gnt_vld && (32'(gnt_idx) == m) && !rtrn_hit[m]) begin
                cnt_d[m] = cnt_q[m] + CntW'(1);
            end else if (!(gnt_vld && (32'(gnt_idx) == m)) && rtrn_hit[m] && (cnt_q[m] != '0)) begin
                cnt_d[m] = cnt_q[m] - CntW'(1);
            end
            if (cnt_d[m] != '0) begin
                cnt_all_zero = 1'b0;
            end
        end

        err_d  = err_q || (mem_rtrn_vld_i && !mem_rtrn_bcast_i && (!src_ok || underflow));
        idle_d = !slot_vld_d && cnt_all_zero;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            slot_vld_q  <= 1'b0;
            slot_src_q  <= '0;
            slot_tid_q  <= '0;
            slot_data_q <= '0;
            ptr_q       <= '0;
            err_q       <= 1'b0;
            idle_q      <= 1'b1;
            for (int unsigned m = 0; m < NumMasters; m++) begin
                cnt_q[m] <= '0;
            end
        end else begin
            slot_vld_q  <= slot_vld_d;
            slot_src_q  <= slot_src_d;
            slot_tid_q  <= slot_tid_d;
            slot_data_q <= slot_data_d;
            ptr_q       <= ptr_d;
            err_q       <= err_d;
            idle_q      <= idle_d;
            for (int unsigned m = 0; m < NumMasters; m++) begin
                cnt_q[m] <= cnt_d[m];
            end
        end
    end

    assign mem_req_o  = slot_vld_q;
    assign mem_tid_o  = {slot_src_q, slot_tid_q};
    assign mem_data_o = slot_data_q;
    assign idle_o     = idle_q;
    assign err_o      = err_q;

endmodule
